// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle main control unit: opcodes, ALU-op codes,
// FSM state codes, instruction classes, and the opcode decode function.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_COMPI = 6'b000010;
    localparam logic [5:0] OP_SHLL  = 6'b000011;
    localparam logic [5:0] OP_SHRL  = 6'b000100;
    localparam logic [5:0] OP_SHRA  = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b000110;
    localparam logic [5:0] OP_SW    = 6'b000111;
    localparam logic [5:0] OP_BR    = 6'b001000;
    localparam logic [5:0] OP_BZ    = 6'b001001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SHLL  = 3'b001;
    localparam logic [2:0] ALU_SHRL  = 3'b010;
    localparam logic [2:0] ALU_SHRA  = 3'b011;
    localparam logic [2:0] ALU_COMPI = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BR      = 3'd3;
    localparam logic [2:0] CLS_BZ      = 3'd4;
    localparam logic [2:0] CLS_HALT    = 3'd5;
    localparam logic [2:0] CLS_ILLEGAL = 3'd6;

    typedef struct packed {
        logic [2:0] cls;
        logic [2:0] alu_op;
        logic       uses_imm;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, uses_imm: 1'b0};
        case (op)
            OP_RTYPE: info = '{cls: CLS_ALU,   alu_op: ALU_RTYPE, uses_imm: 1'b0};
            OP_ADDI:  info = '{cls: CLS_ALU,   alu_op: ALU_ADD,   uses_imm: 1'b1};
            OP_COMPI: info = '{cls: CLS_ALU,   alu_op: ALU_COMPI, uses_imm: 1'b1};
            OP_SHLL:  info = '{cls: CLS_ALU,   alu_op: ALU_SHLL,  uses_imm: 1'b1};
            OP_SHRL:  info = '{cls: CLS_ALU,   alu_op: ALU_SHRL,  uses_imm: 1'b1};
            OP_SHRA:  info = '{cls: CLS_ALU,   alu_op: ALU_SHRA,  uses_imm: 1'b1};
            OP_LW:    info = '{cls: CLS_LOAD,  alu_op: ALU_ADD,   uses_imm: 1'b1};
            OP_SW:    info = '{cls: CLS_STORE, alu_op: ALU_ADD,   uses_imm: 1'b1};
            OP_BR:    info = '{cls: CLS_BR,    alu_op: ALU_ADD,   uses_imm: 1'b0};
            OP_BZ:    info = '{cls: CLS_BZ,    alu_op: ALU_ADD,   uses_imm: 1'b0};
            OP_HALT:  info = '{cls: CLS_HALT,  alu_op: ALU_ADD,   uses_imm: 1'b0};
            default:  ;
        endcase
        return info;
    endfunction

    function automatic logic [2:0] op_class(input logic [5:0] op);
        op_info_t info;
        info = decode_op(op);
        return info.cls;
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode decoder: opcode -> instruction class, ALU operation, immediate select.
module op_class_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic [2:0] o_cls,
    output logic [2:0] o_alu_op,
    output logic       o_uses_imm
);

    op_info_t w_info;

    always_comb begin
        w_info = decode_op(i_opcode);
    end

    assign o_cls      = w_info.cls;
    assign o_alu_op   = w_info.alu_op;
    assign o_uses_imm = w_info.uses_imm;

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory handshake timeout.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes and export the illegal_op port.
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       retired,
    output logic       halted,
    output logic       mem_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [5:0]    r_op_q;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_err;
    logic [2:0]    w_cls;
    logic [2:0]    w_alu_op;
    logic          w_uses_imm;
    logic [2:0]    w_dec_cls;
    logic          w_timeout;

    op_class_decode u_op_class_decode (
        .i_opcode   (r_op_q),
        .o_cls      (w_cls),
        .o_alu_op   (w_alu_op),
        .o_uses_imm (w_uses_imm)
    );

    // DECODE must steer on the incoming opcode; op_q only holds it from EXEC on.
    always_comb begin
        w_dec_cls = op_class(opcode);
    end

    assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready
                       && (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        retired      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (w_dec_cls == CLS_HALT) begin
                    w_next_state = ST_HALT;
                end else if (w_dec_cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    retired      = 1'b1;
                    w_next_state = ST_FETCH;
`endif
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op      = w_alu_op;
                alu_src_imm = w_uses_imm;
                case (w_cls)
                    CLS_ALU:              w_next_state = ST_WB;
                    CLS_LOAD, CLS_STORE:  w_next_state = ST_MEM;
                    CLS_BR: begin
                        pc_load      = 1'b1;
                        retired      = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    CLS_BZ: begin
                        pc_load      = zero_flag;
                        retired      = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    default:              w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_write = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    retired      = (w_cls == CLS_STORE);
                    w_next_state = (w_cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = (w_cls == CLS_LOAD);
                retired      = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: w_next_state = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: w_next_state = ST_TRAP;
`endif
            default: w_next_state = ST_FETCH;
        endcase
        // NOTE: reset forces state to FETCH, whose mem_ready-driven enables would
        // otherwise leak out while rst_n is low; gate them so reset drops mem_req at once.
        if (!rst_n) begin
            mem_req  = 1'b0;
            ir_write = 1'b0;
            pc_inc   = 1'b0;
        end
    end

    assign halted  = (r_state == ST_HALT);
    assign mem_err = r_mem_err;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates at the edge see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_op_q     <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_op_q <= opcode;
            end
            if (mem_req) begin
                if (mem_ready || w_timeout) begin
                    r_wait_cnt <= '0;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (w_timeout) begin
                    r_mem_err <= 1'b1;
                end
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_op <= 1'b0;
        end else if (r_state == ST_DECODE && w_next_state == ST_TRAP) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign illegal_op = r_illegal_op;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares against the sampled DUT outputs.
module tb_main_control_fsm;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_inc;
        logic       pc_load;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retired;
        logic       halted;
        logic       mem_err;
        logic       illegal_op;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, ir_write, pc_inc, pc_load;
    logic [2:0] alu_op;
    logic       alu_src_imm, reg_write, mem_to_reg, retired, halted, mem_err;
    logic       illegal_op;

    out_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    main_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero_flag   (zero_flag),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .retired     (retired),
        .halted      (halted),
        .mem_err     (mem_err)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal_op = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one expected output vector per clock cycle, compared mid-cycle.
    always @(negedge clk) begin
        out_t  e;
        out_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{mem_req, mem_write, ir_write, pc_inc, pc_load, alu_op, alu_src_imm,
                   reg_write, mem_to_reg, retired, halted, mem_err, illegal_op};
            check(nm, 32'(a), 32'(e));
        end
    end

    function automatic out_t o_fetch(input logic done);
        out_t o = '0;
        o.mem_req  = 1'b1;
        o.ir_write = done;
        o.pc_inc   = done;
        return o;
    endfunction

    function automatic out_t o_exec(input logic [2:0] alu, input logic imm,
                                    input logic pcl, input logic ret);
        out_t o = '0;
        o.alu_op      = alu;
        o.alu_src_imm = imm;
        o.pc_load     = pcl;
        o.retired     = ret;
        return o;
    endfunction

    function automatic out_t o_mem(input logic we, input logic ret);
        out_t o = '0;
        o.mem_req   = 1'b1;
        o.mem_write = we;
        o.retired   = ret;
        return o;
    endfunction

    function automatic out_t o_wb(input logic m2r);
        out_t o = '0;
        o.reg_write  = 1'b1;
        o.mem_to_reg = m2r;
        o.retired    = 1'b1;
        return o;
    endfunction

    function automatic out_t o_halt(input logic err);
        out_t o = '0;
        o.halted  = 1'b1;
        o.mem_err = err;
        return o;
    endfunction

    // Drives one cycle's inputs just after the rising edge and queues its expected outputs.
    task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                       input logic rdy, input logic zf, input out_t e);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        mem_ready = rdy;
        zero_flag = zf;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic front(input string nm, input logic [5:0] op);
        cyc({nm, "_fetch"},  1'b1, op, 1'b1, 1'b0, o_fetch(1'b1));
        cyc({nm, "_decode"}, 1'b1, op, 1'b1, 1'b0, '0);
    endtask

    task automatic run_alu(input string nm, input logic [5:0] op,
                           input logic [2:0] alu, input logic imm);
        front(nm, op);
        cyc({nm, "_exec"}, 1'b1, op, 1'b1, 1'b0, o_exec(alu, imm, 1'b0, 1'b0));
        cyc({nm, "_wb"},   1'b1, op, 1'b1, 1'b0, o_wb(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc("reset_0", 1'b0, OP_ADDI, 1'b1, 1'b0, '0);
        cyc("reset_1", 1'b0, OP_ADDI, 1'b1, 1'b0, '0);

        run_alu("addi",  OP_ADDI,  ALU_ADD,   1'b1);
        run_alu("shra",  OP_SHRA,  ALU_SHRA,  1'b1);
        run_alu("rtype", OP_RTYPE, ALU_RTYPE, 1'b0);
        run_alu("compi", OP_COMPI, ALU_COMPI, 1'b1);

        front("lw", OP_LW);
        cyc("lw_exec", 1'b1, OP_LW, 1'b1, 1'b0, o_exec(ALU_ADD, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b1, OP_LW, 1'b0, 1'b0, o_mem(1'b0, 1'b0));
        cyc("lw_mem_done", 1'b1, OP_LW, 1'b1, 1'b0, o_mem(1'b0, 1'b0));
        cyc("lw_wb",       1'b1, OP_LW, 1'b1, 1'b0, o_wb(1'b1));

        front("sw", OP_SW);
        cyc("sw_exec", 1'b1, OP_SW, 1'b1, 1'b0, o_exec(ALU_ADD, 1'b1, 1'b0, 1'b0));
        cyc("sw_mem",  1'b1, OP_SW, 1'b1, 1'b0, o_mem(1'b1, 1'b1));

        front("bz_taken", OP_BZ);
        cyc("bz_taken_exec", 1'b1, OP_BZ, 1'b1, 1'b1, o_exec(ALU_ADD, 1'b0, 1'b1, 1'b1));
        front("bz_not", OP_BZ);
        cyc("bz_not_exec",   1'b1, OP_BZ, 1'b1, 1'b0, o_exec(ALU_ADD, 1'b0, 1'b0, 1'b1));
        front("br", OP_BR);
        cyc("br_exec",       1'b1, OP_BR, 1'b1, 1'b0, o_exec(ALU_ADD, 1'b0, 1'b1, 1'b1));

        // Ready arrives on the 16th waiting cycle: the transfer must win over the timeout.
        for (int i = 0; i < 15; i++) cyc("slow_fetch_wait", 1'b1, OP_ADDI, 1'b0, 1'b0, o_fetch(1'b0));
        run_alu("slow_addi", OP_ADDI, ALU_ADD, 1'b1);

        cyc("illegal_fetch", 1'b1, 6'b010101, 1'b1, 1'b0, o_fetch(1'b1));
`ifdef ILLEGAL_TRAP_EN
        cyc("illegal_decode", 1'b1, 6'b010101, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            out_t t;
            t = '0;
            t.illegal_op = 1'b1;
            cyc("illegal_trap", 1'b1, OP_ADDI, 1'b1, 1'b0, t);
        end
        cyc("illegal_reset", 1'b0, OP_ADDI, 1'b0, 1'b0, '0);
`else
        begin
            out_t t;
            t = '0;
            t.retired = 1'b1;
            cyc("illegal_nop_decode", 1'b1, 6'b010101, 1'b1, 1'b0, t);
        end
`endif

        front("lw_abort", OP_LW);
        cyc("lw_abort_exec", 1'b1, OP_LW, 1'b1, 1'b0, o_exec(ALU_ADD, 1'b1, 1'b0, 1'b0));
        cyc("lw_abort_mem",  1'b1, OP_LW, 1'b0, 1'b0, o_mem(1'b0, 1'b0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_mem_req_drop", 32'(mem_req), 32'd0);
        check("mid_mem_no_retire", 32'(retired), 32'd0);
        cyc("mid_mem_reset", 1'b0, OP_ADDI, 1'b1, 1'b0, '0);
        run_alu("post_reset_addi", OP_ADDI, ALU_ADD, 1'b1);

        front("halt", OP_HALT);
        for (int i = 0; i < 3; i++) cyc("halt_hold", 1'b1, OP_ADDI, 1'b1, 1'b0, o_halt(1'b0));
        cyc("halt_reset", 1'b0, OP_ADDI, 1'b0, 1'b0, '0);

        for (int i = 0; i < 16; i++) cyc("timeout_wait", 1'b1, OP_ADDI, 1'b0, 1'b0, o_fetch(1'b0));
        for (int i = 0; i < 2; i++) cyc("timeout_halt", 1'b1, OP_ADDI, 1'b1, 1'b0, o_halt(1'b1));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
